// File: rtl/tqvp_htfab_vga_capture.sv
// TinyQV peripheral that grabs a 32x16 monochrome snapshot of a 1-bit VGA stream.
// States: IDLE | no capture; WAIT_VS | waiting for vsync end; LINES | counting/sampling lines; DONE | one-cycle frame-complete
module tqvp_htfab_vga_capture #(
  parameter logic [31:0] DEF_TIMING = 32'h1E30_3393
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, LINES = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q;
  logic [31:0] timing_q;
  logic [31:0] rows_q [16];
  logic [31:0] line_buf_q;
  logic [7:0]  line_q;
  logic        started_q;
  logic        capturing_q;
  logic [12:0] next_line_q;
  logic [13:0] hcnt_q;
  logic [13:0] next_col_q;
  logic [4:0]  col_q;
  logic [3:0]  row_idx_q;
  logic        continuous_q;
  logic        done_q;

  logic [7:0]  h_start, h_step, v_start, v_step;
  logic        vs_fall, vs_rise, hs_rise, pixel;
  logic        ctrl_wr, timing_wr, clr;
  logic        lines_active, col_hit, commit, last_row, cap_next, rd_req;
  logic [31:0] commit_data;
  logic [7:0]  line_next;
  logic [12:0] next_line_eff;
  logic [7:0]  status;
  logic        unused_ok;

  assign h_start = timing_q[7:0];
  assign h_step  = (timing_q[15:8] == 8'd0) ? 8'd1 : timing_q[15:8];
  assign v_start = timing_q[23:16];
  assign v_step  = (timing_q[31:24] == 8'd0) ? 8'd1 : timing_q[31:24];

  assign vs_fall = sync_q[2] & ~ui_in[2];
  assign vs_rise = ~sync_q[2] & ui_in[2];
  assign hs_rise = ~sync_q[1] & ui_in[1];
  assign pixel   = sync_q[0];

  assign ctrl_wr   = (data_write_n == 2'b00);
  assign timing_wr = (data_write_n == 2'b10);
  assign clr       = ctrl_wr & (data_in[0] | data_in[2]);

  assign lines_active = (state_q == LINES) && !vs_fall;
  assign col_hit      = lines_active && capturing_q && (hcnt_q == next_col_q);
  assign commit       = lines_active && capturing_q && ((col_hit && col_q == 5'd31) || hs_rise);
  assign last_row     = commit && (row_idx_q == 4'd15);
  assign commit_data  = col_hit ? (line_buf_q | ({31'b0, pixel} << col_q)) : line_buf_q;

  // The first hs_rise of a frame opens line 0; later ones advance, saturating at 255.
  assign line_next     = !started_q ? 8'd0 : (line_q == 8'hFF) ? line_q : line_q + 8'd1;
  assign next_line_eff = commit ? next_line_q + {5'b0, v_step} : next_line_q;
  assign cap_next      = hs_rise && ({5'b0, line_next} == next_line_eff) && !last_row;

  assign status = {row_idx_q, 1'b0, continuous_q, done_q, (state_q != IDLE)};
  assign rd_req = (data_read_n != 2'b11) && !data_ready;

  assign uo_out         = {5'b0, sync_q};
  assign user_interrupt = done_q;
  assign unused_ok      = &{1'b0, ui_in[7:3], address[1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      WAIT_VS: if (vs_rise) state_d = LINES;
      LINES: begin
        if (vs_fall)       state_d = WAIT_VS;
        else if (last_row) state_d = DONE;
      end
      DONE:    state_d = continuous_q ? WAIT_VS : IDLE;
      default: state_d = IDLE;
    endcase
    if (ctrl_wr) begin
      if (data_in[0])      state_d = WAIT_VS;
      else if (data_in[3]) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= 3'b0;
      timing_q     <= DEF_TIMING;
      for (int i = 0; i < 16; i++) rows_q[i] <= 32'b0;
      line_buf_q   <= 32'b0;
      line_q       <= 8'd0;
      started_q    <= 1'b0;
      capturing_q  <= 1'b0;
      next_line_q  <= 13'd0;
      hcnt_q       <= 14'd0;
      next_col_q   <= 14'd0;
      col_q        <= 5'd0;
      row_idx_q    <= 4'd0;
      continuous_q <= 1'b0;
      done_q       <= 1'b0;
      data_out     <= 32'b0;
      data_ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= ui_in[2:0];

      if (timing_wr) timing_q <= data_in;
      if (ctrl_wr) continuous_q <= data_in[1];
      // A clearing control write beats the DONE-cycle set.
      if (clr)                    done_q <= 1'b0;
      else if (state_q == DONE)   done_q <= 1'b1;

      if (hs_rise)                 hcnt_q <= 14'd0;
      else if (hcnt_q != 14'h3FFF) hcnt_q <= hcnt_q + 14'd1;

      if (state_q == WAIT_VS && vs_rise) begin
        line_q      <= 8'd0;
        started_q   <= 1'b0;
        capturing_q <= 1'b0;
        row_idx_q   <= 4'd0;
        next_line_q <= {5'b0, v_start};
      end else if (lines_active) begin
        if (commit) begin
          rows_q[row_idx_q] <= commit_data;
          row_idx_q         <= row_idx_q + 4'd1;
          next_line_q       <= next_line_eff;
          capturing_q       <= 1'b0;
        end
        if (col_hit) begin
          line_buf_q[col_q] <= pixel;
          col_q             <= col_q + 5'd1;
          next_col_q        <= next_col_q + {6'b0, h_step};
        end
        if (hs_rise) begin
          started_q   <= 1'b1;
          line_q      <= line_next;
          capturing_q <= cap_next;
          line_buf_q  <= 32'b0;
          col_q       <= 5'd0;
          next_col_q  <= {6'b0, h_start};
        end
      end

      if (rd_req) begin
        data_ready <= 1'b1;
        data_out   <= (data_read_n == 2'b10) ? rows_q[address[5:2]] : {24'b0, status};
      end else begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule
